regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read integer register file for the RV32I core.
- Width, depth and read-port count are configurable; x0 is hardwired to zero.
- Adds an asynchronous clear and a per-register pending-write scoreboard, so the pipelined decode stage can detect RAW hazards.
- Sits between decode (read/issue) and writeback (write/retire).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (16 for RV32E builds; must be a power of two, at least 2)
NUM_RD, 2, number of independent combinational read ports (1..4)
AW, $clog2(NREGS), localparam, register address width

Ports:
clk  input  1  core clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = asserted); clears all registers and the scoreboard
rs_addr  input  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW]
rs_data  output  NUM_RD*XLEN  packed read data for port i
rs_busy  output  NUM_RD  port i source has an outstanding (issued, not retired) write
we  input  1  writeback enable
wr_addr  input  AW  writeback destination register
wr_data  input  XLEN  writeback data
issue_valid  input  1  an instruction with a destination register issues this cycle
issue_rd  input  AW  destination of the issuing instruction
flush  input  1  pipeline flush; clears all busy bits
any_busy  output  1  OR of all busy bits; used by the fence/CSR drain logic

Behaviour:
- Reset (reset=0, asynchronous):
  - all NREGS registers are set to 0 and all busy bits to 0 immediately, with no clock needed;
  - rs_data therefore reads 0, and rs_busy and any_busy read 0;
  - on deassertion, state updates resume at the next rising edge of clk;
  - reset asserted mid-operation discards any write or issue in flight that cycle.
- Write:
  - at the rising edge, if we=1 and wr_addr!=0, then reg[wr_addr] <= wr_data;
  - wr_addr=0 is silently dropped.
  - Writes use the rising edge, not the falling edge; same-cycle visibility is provided only by the optional bypass.
- Read:
  - purely combinational, zero latency; rs_data[i] = reg[rs_addr[i]];
  - rs_addr[i]=0 always yields 0 and rs_busy[i]=0;
  - all ports are independent, and the same address on several ports is legal.
- Scoreboard: one busy bit per register; bit 0 is constant 0. Priority at each rising edge, highest first:
  - flush=1: all busy bits are cleared and issue_valid is ignored that cycle. A same-cycle writeback still updates reg.
  - issue_valid=1 and issue_rd!=0: busy[issue_rd] <= 1. This takes precedence over a same-cycle retire of the same register, because the newer producer owns the bit.
  - we=1 and wr_addr!=0: busy[wr_addr] <= 0.
  - Issue and retire to different registers in the same cycle: both take effect.
- rs_busy[i] = busy[rs_addr[i]], modified by the optional feature below.
- any_busy = |busy; registered-state only, with no combinational path from the inputs.
- issue_valid to a register that is already busy is legal; the bit stays 1.
- A retire to a non-busy register is legal; the bit stays 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1, wr_addr!=0 and wr_addr==rs_addr[i], then:
  - rs_data[i]=wr_data in the same cycle;
  - rs_busy[i]=0 in the same cycle, unless issue_valid targets that register in the same cycle, in which case it remains as stored.
- Undefined: no forwarding. rs_data and rs_busy reflect stored state only, and the written value becomes visible from the cycle after the edge.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT=32;
  - NREGS_RV32I=32 and NREGS_RV32E=16;
  - the ZERO_REG constant (0);
  - a reg_addr_t typedef sized for 32 registers.
- One sub-module, regfile_scoreboard, holds the busy vector, the priority logic and any_busy.
- The data array, read muxing and bypass stay in regfile_mp.

Test Plan:
- Reset low with a previously written x5=0xDEADBEEF -> rs_data=0 for x5 immediately, before any clk edge; any_busy=0.
- Write x0=0xFFFFFFFF, then read x0 on all ports -> 0; issue_rd=0 -> any_busy remains 0.
- Write x7=0x12345678 while reading x7 on the same cycle -> with REGFILE_BYPASS_EN, 0x12345678 that cycle; without it, the old value that cycle and 0x12345678 the next.
- Issue x3, then 2 idle cycles, then retire x3 -> rs_busy for x3 is 1 for those cycles and 0 after the retire edge. Issue and retire x3 on the same edge -> busy stays 1.
- Issue x4, x9 and x12, then assert flush together with issue x6 -> all busy bits 0, x6 not set, any_busy=0.
- NUM_RD=4, NREGS=16: write x1..x15 with their index values, read {x15,x1,x15,x0} -> {15,1,15,0}.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the parametrised RV32I/RV32E register file.
//   XLEN_DEFAULT : default register width
//   NREGS_RV32I  : architectural register count for RV32I
//   NREGS_RV32E  : architectural register count for RV32E
//   ZERO_REG     : index of the hardwired-zero register x0
//   reg_addr_t   : register index type sized for a 32-entry file
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_RV32I  = 32;
  localparam int NREGS_RV32E  = 16;
  localparam int ZERO_REG     = 0;

  typedef logic [$clog2(NREGS_RV32I)-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write scoreboard: one busy bit per architectural register, set when
// an instruction with that destination issues and cleared when it retires.
// Bit 0 (x0) is permanently zero.
//
// Ports:
//   clk_i         : core clock, rising edge
//   rst_ni        : asynchronous active-low reset, clears every busy bit
//   flush_i       : clears every busy bit, overrides a same-cycle issue
//   issue_valid_i : an instruction with destination issue_rd_i issues
//   issue_rd_i    : destination register of the issuing instruction
//   we_i          : writeback (retire) enable
//   wr_addr_i     : register being retired
//   busy_o        : registered busy vector, one bit per register
//   any_busy_o    : OR of all busy bits (registered state only)
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_RV32I,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rd_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  output logic [NREGS-1:0] busy_o,
  output logic             any_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Retire is applied before issue so that a same-register issue wins:
  // the newer producer owns the bit.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (we_i && (wr_addr_i != AW'(ZERO_REG))) begin
        busy_d[wr_addr_i] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != AW'(ZERO_REG))) begin
        busy_d[issue_rd_i] = 1'b1;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-read-port integer register file with hardwired x0,
// asynchronous clear and a pending-write scoreboard for RAW hazard detection.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   : same-cycle write-to-read forwarding of data and busy
//   undefined : reads reflect stored state only
//
// Ports:
//   clk         : core clock, all state updates on its rising edge
//   reset       : asynchronous active-low reset; clears registers and scoreboard
//   rs_addr     : packed read addresses, port i at [i*AW +: AW]
//   rs_data     : packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy     : per-port busy flag of the addressed source register
//   we          : writeback enable
//   wr_addr     : writeback destination register
//   wr_data     : writeback data
//   issue_valid : an instruction with a destination register issues
//   issue_rd    : destination of the issuing instruction
//   flush       : pipeline flush, clears all busy bits
//   any_busy    : OR of all busy bits
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_RV32I,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   flush,
  output logic                   any_busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic             wr_valid;

  assign wr_valid = we && (wr_addr != AW'(ZERO_REG));

  // Entry 0 is cleared by reset and never written, so x0 reads as zero
  // without a dedicated read-side mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i         (clk),
    .rst_ni        (reset),
    .flush_i       (flush),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .we_i          (we),
    .wr_addr_i     (wr_addr),
    .busy_o        (busy_vec),
    .any_busy_o    (any_busy)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rs_addr[gi*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by reset so that an asserted reset always
      // reads back as an all-zero file.
      if (reset && wr_valid && (wr_addr == addr)) begin
        data = wr_data;
        if (!(issue_valid && (issue_rd == addr))) begin
          busy = 1'b0;
        end
      end
`endif
    end

    assign rs_data[gi*XLEN +: XLEN] = data;
    assign rs_busy[gi]              = busy;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int NUM_RD = 4;
  localparam int AW     = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rs_addr;
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   we;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   flush;
  logic                   any_busy;

  regfile_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .any_busy    (any_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural contents and set of pending destinations
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit fwd_hit(input logic [AW-1:0] a);
    return BYPASS && reset && we && (wr_addr != 0) && (wr_addr == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int p);
    logic [AW-1:0] a;
    a = rs_addr[p*AW +: AW];
    if (fwd_hit(a)) return wr_data;
    return (a == 0) ? '0 : m_regs[a];
  endfunction

  function automatic logic exp_busy(input int p);
    logic [AW-1:0] a;
    a = rs_addr[p*AW +: AW];
    if (a == 0) return 1'b0;
    if (fwd_hit(a) && !(issue_valid && issue_rd == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NREGS; i++) r |= m_busy[i];
    return r;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_all();
    if (!reset) model_clear();
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("rd%0d_data", p), rs_data[p*XLEN +: XLEN], exp_data(p));
      chk($sformatf("rd%0d_busy", p), 32'(rs_busy[p]), 32'(exp_busy(p)));
    end
    chk("any_busy", 32'(any_busy), 32'(exp_any()));
  endtask

  // State change at a rising edge, from the architectural rules.
  task automatic model_edge();
    if (!reset) begin
      model_clear();
    end else begin
      if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else begin
        if (we && wr_addr != 0) m_busy[wr_addr] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    $display("cyc %0d rst=%b we=%b wa=%0d wd=%h iv=%b ir=%0d fl=%b ra=%h data=%h busy=%b any=%b",
             cyc, reset, we, wr_addr, wr_data, issue_valid, issue_rd, flush, rs_addr,
             rs_data, rs_busy, any_busy);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rs_addr = {a3, a2, a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    issue_valid = 1'b1; issue_rd = a;
  endtask

  initial begin
    model_clear();
    reset = 1'b0;
    idle();
    set_rd(0, 0, 0, 0);
    #2;
    chk("init_any_busy", 32'(any_busy), 32'd0);
    cycle();
    reset = 1'b1;
    cycle();

    // x5 written and issued on the same edge, then asynchronous reset
    wr(5, 32'hDEADBEEF); iss(5); set_rd(5, 5, 5, 5);
    cycle();
    idle();
    #1;
    chk("x5_written", rs_data[31:0], 32'hDEADBEEF);
    chk("x5_busy_issue_wins", 32'(rs_busy[0]), 32'd1);
    chk("any_busy_x5", 32'(any_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_data", rs_data[31:0], 32'd0);
    chk("async_rst_busy", 32'(rs_busy), 32'd0);
    chk("async_rst_any", 32'(any_busy), 32'd0);
    wr(5, 32'h11111111); iss(5);
    cycle();
    reset = 1'b1;
    idle();
    #1;
    chk("rst_discards_write", rs_data[31:0], 32'd0);
    cycle();

    // x0 is hardwired to zero
    wr(0, 32'hFFFFFFFF); iss(0); set_rd(0, 0, 0, 0);
    cycle();
    idle();
    #1;
    for (int p = 0; p < NUM_RD; p++) chk($sformatf("x0_rd%0d", p), rs_data[p*XLEN +: XLEN], 32'd0);
    chk("x0_any_busy", 32'(any_busy), 32'd0);
    cycle();

    // Write/read same cycle on x7
    wr(7, 32'hAAAA0000);
    cycle();
    wr(7, 32'h12345678); set_rd(7, 7, 7, 7);
    #1;
    chk("x7_same_cycle", rs_data[31:0], BYPASS ? 32'h12345678 : 32'hAAAA0000);
    cycle();
    idle();
    #1;
    chk("x7_next_cycle", rs_data[31:0], 32'h12345678);
    cycle();

    // Issue x3, two idle cycles, retire x3
    iss(3); set_rd(3, 0, 3, 0);
    cycle();
    idle();
    #1; chk("x3_busy_c1", 32'(rs_busy[0]), 32'd1);
    cycle();
    #1; chk("x3_busy_c2", 32'(rs_busy[0]), 32'd1);
    cycle();
    wr(3, 32'h33);
    #1; chk("x3_busy_retire_cycle", 32'(rs_busy[0]), BYPASS ? 32'd0 : 32'd1);
    cycle();
    idle();
    #1; chk("x3_busy_after_retire", 32'(rs_busy[0]), 32'd0);
    cycle();
    wr(3, 32'h34); iss(3);
    cycle();
    idle();
    #1; chk("x3_issue_retire_same", 32'(rs_busy[0]), 32'd1);
    wr(3, 32'h35);
    cycle();
    idle();
    cycle();

    // Flush beats a same-cycle issue
    iss(4);  cycle();
    iss(9);  cycle();
    iss(12); cycle();
    idle();
    set_rd(4, 9, 12, 6);
    #1; chk("pre_flush_any", 32'(any_busy), 32'd1);
    chk("pre_flush_busy", 32'(rs_busy), 32'b0111);
    flush = 1'b1; iss(6);
    cycle();
    idle();
    #1;
    chk("post_flush_any", 32'(any_busy), 32'd0);
    chk("post_flush_busy", 32'(rs_busy), 32'd0);
    cycle();

    // x1..x15 loaded with their index
    for (int i = 1; i < NREGS; i++) begin
      wr(AW'(i), XLEN'(i));
      cycle();
    end
    idle();
    set_rd(15, 1, 15, 0);
    #1;
    chk("mp_rd0", rs_data[0*XLEN +: XLEN], 32'd15);
    chk("mp_rd1", rs_data[1*XLEN +: XLEN], 32'd1);
    chk("mp_rd2", rs_data[2*XLEN +: XLEN], 32'd15);
    chk("mp_rd3", rs_data[3*XLEN +: XLEN], 32'd0);
    cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 199) != 0);
      we          = 1'($urandom_range(0, 1));
      wr_addr     = AW'($urandom_range(0, NREGS - 1));
      wr_data     = XLEN'($urandom);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      flush       = ($urandom_range(0, 15) == 0);
      rs_addr     = NUM_RD*AW'($urandom);
      if ($urandom_range(0, 3) == 0) rs_addr[AW-1:0] = wr_addr;
      cycle();
    end
    reset = 1'b1;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
